// File: rtl/bf16_adder_if.sv
// ============================================================================
// Module   : bf16_adder_if
// Brief    : Operand/result bundle for the single-stage BF16 adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bf16_adder_if;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        input  sum,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output sum,
        output out_valid
    );
endinterface

`default_nettype wire

// File: rtl/bf16_adder.sv
// ============================================================================
// Module   : bf16_adder
// Brief    : One-cycle BF16 adder with input/output flush-to-zero.
//            BF16_ADDER_RNE_EN selects round-to-nearest-even, else truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_adder (
    input  wire          clk,
    input  wire          rst_n,
    bf16_adder_if.slave  bus
);

    // ---------------- unpack ----------------
    logic [7:0] w_a_exp, w_b_exp, w_a_man, w_b_man;
    logic       w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

    assign w_a_exp  = bus.a[14:7];
    assign w_b_exp  = bus.b[14:7];
    assign w_a_zero = (w_a_exp == 8'h00);
    assign w_b_zero = (w_b_exp == 8'h00);
    assign w_a_nan  = (&w_a_exp) & (|bus.a[6:0]);
    assign w_b_nan  = (&w_b_exp) & (|bus.b[6:0]);
    assign w_a_inf  = (&w_a_exp) & ~(|bus.a[6:0]);
    assign w_b_inf  = (&w_b_exp) & ~(|bus.b[6:0]);
    assign w_a_man  = w_a_zero ? 8'h00 : {1'b1, bus.a[6:0]};
    assign w_b_man  = w_b_zero ? 8'h00 : {1'b1, bus.b[6:0]};

    // ---------------- swap / align ----------------
    logic        w_a_ge, w_l_sign, w_eff_sub;
    logic [7:0]  w_l_exp, w_s_exp, w_l_man, w_s_man, w_shift;
    logic [18:0] w_wide;
    logic [10:0] w_l_al, w_s_al, w_sub;
    logic [11:0] w_add;

    assign w_a_ge    = ({w_a_exp, w_a_man} >= {w_b_exp, w_b_man});
    assign w_l_exp   = w_a_ge ? w_a_exp : w_b_exp;
    assign w_s_exp   = w_a_ge ? w_b_exp : w_a_exp;
    assign w_l_man   = w_a_ge ? w_a_man : w_b_man;
    assign w_s_man   = w_a_ge ? w_b_man : w_a_man;
    assign w_l_sign  = w_a_ge ? bus.a[15] : bus.b[15];
    assign w_eff_sub = bus.a[15] ^ bus.b[15];
    assign w_shift   = w_l_exp - w_s_exp;

    // Guard, round and sticky sit below the 8-bit mantissa; bit 0 collects sticky.
    assign w_wide = {w_s_man, 11'b0} >> w_shift;
    assign w_s_al = (w_shift >= 8'd11) ? {10'b0, |w_s_man}
                                       : {w_wide[18:9], |w_wide[8:0]};
    assign w_l_al = {w_l_man, 3'b000};
    assign w_add  = {1'b0, w_l_al} + {1'b0, w_s_al};
    assign w_sub  = w_l_al - w_s_al;

    // ---------------- normalise ----------------
    logic [3:0]  w_lzc;
    logic        w_found;
    logic [10:0] w_m_norm;
    logic [9:0]  w_e_norm;
    logic        w_exact_zero, w_underflow;

    always_comb begin
        w_lzc    = 4'd0;
        w_found  = 1'b0;
        w_m_norm = 11'd0;
        w_e_norm = 10'd0;
        for (int i = 10; i >= 0; i--) begin
            if (!w_found) begin
                if (w_sub[i]) w_found = 1'b1;
                else          w_lzc   = w_lzc + 4'd1;
            end
        end
        if (!w_eff_sub) begin
            if (w_add[11]) begin
                w_m_norm = {w_add[11:2], |w_add[1:0]};
                w_e_norm = {2'b00, w_l_exp} + 10'd1;
            end else begin
                w_m_norm = w_add[10:0];
                w_e_norm = {2'b00, w_l_exp};
            end
        end else begin
            w_m_norm = w_sub << w_lzc;
            w_e_norm = {2'b00, w_l_exp} - {6'b0, w_lzc};
        end
    end

    assign w_exact_zero = w_eff_sub & (w_sub == 11'd0);
    assign w_underflow  = w_e_norm[9] | (w_e_norm == 10'd0);

    // ---------------- round ----------------
    logic [6:0] w_frac;
    logic [9:0] w_e_fin;

`ifdef BF16_ADDER_RNE_EN
    logic       w_round_up;
    logic [8:0] w_man_rnd;
    logic       w_unused_hidden;

    assign w_round_up      = w_m_norm[2] & (w_m_norm[1] | w_m_norm[0] | w_m_norm[3]);
    assign w_man_rnd       = {1'b0, w_m_norm[10:3]} + {8'b0, w_round_up};
    assign w_frac          = w_man_rnd[8] ? 7'h00 : w_man_rnd[6:0];
    assign w_e_fin         = w_man_rnd[8] ? (w_e_norm + 10'd1) : w_e_norm;
    assign w_unused_hidden = w_man_rnd[7];
`else
    logic w_unused_grs;

    assign w_frac       = w_m_norm[9:3];
    assign w_e_fin      = w_e_norm;
    assign w_unused_grs = ^{w_m_norm[10], w_m_norm[2:0]};
`endif

    // ---------------- result select ----------------
    logic [15:0] w_res;

    always_comb begin
        w_res = {w_l_sign, w_e_fin[7:0], w_frac};
        if (w_a_nan | w_b_nan)
            w_res = 16'h7FC0;
        else if (w_a_inf & w_b_inf & w_eff_sub)
            w_res = 16'h7FC0;
        else if (w_a_inf)
            w_res = {bus.a[15], 8'hFF, 7'h00};
        else if (w_b_inf)
            w_res = {bus.b[15], 8'hFF, 7'h00};
        else if (w_a_zero & w_b_zero)
            w_res = {bus.a[15] & bus.b[15], 15'h0000};
        else if (w_exact_zero)
            w_res = 16'h0000;
        else if (w_underflow)
            w_res = {w_l_sign, 15'h0000};
        else if (w_e_fin >= 10'd255)
            w_res = {w_l_sign, 8'hFF, 7'h00};
    end

    // ---------------- output register ----------------
    logic [15:0] r_sum;
    logic        r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) r_sum <= w_res;
        end
    end

    assign bus.sum       = r_sum;
    assign bus.out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_bf16_adder.sv
// ============================================================================
// Module   : tb_bf16_adder
// Brief    : Table-driven scoreboard bench for bf16_adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf16_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bf16_adder_if bus ();

    bf16_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    localparam int NV = 18;
    vec_t        vecs [NV];
    logic [15:0] sb_q [$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_sum = 16'h0000;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one comparison set per rising edge while out of reset.
    always @(posedge clk) begin
        logic pend;
        logic [15:0] want;
        pend = bus.in_valid;
        #1;
        if (rst_n) begin
            check("out_valid", {15'b0, bus.out_valid}, {15'b0, pend});
            if (pend) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underrun", 16'h0001, 16'h0000);
                end else begin
                    want = sb_q.pop_front();
                    check("sum", bus.sum, want);
                end
            end else begin
                check("sum_hold", bus.sum, last_sum);
            end
            last_sum = bus.sum;
        end else begin
            last_sum = 16'h0000;
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] y);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        sb_q.push_back(y);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = 16'h1234;
        bus.b        = 16'h5678;

        vecs[0]  = '{16'h3FC0, 16'h4020, 16'h4080};
        vecs[1]  = '{16'h40B0, 16'h4124, 16'h417C};
        vecs[2]  = '{16'hC000, 16'hC040, 16'hC0A0};
        vecs[3]  = '{16'hBF80, 16'h3F80, 16'h0000};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{16'h8000, 16'h8000, 16'h8000};
        vecs[6]  = '{16'h7F80, 16'hFF80, 16'h7FC0};
        vecs[7]  = '{16'h7FC1, 16'h3F80, 16'h7FC0};
        vecs[8]  = '{16'h7F7F, 16'h7F7F, 16'h7F80};
        vecs[9]  = '{16'h0001, 16'h3F80, 16'h3F80};
        vecs[10] = '{16'h3F80, 16'h3B80, 16'h3F80};
`ifdef BF16_ADDER_RNE_EN
        vecs[11] = '{16'h3F81, 16'h3B80, 16'h3F82};
`else
        vecs[11] = '{16'h3F81, 16'h3B80, 16'h3F81};
`endif
        vecs[12] = '{16'hFF80, 16'h3F80, 16'hFF80};
        vecs[13] = '{16'h3F80, 16'hBF00, 16'h3F00};
        vecs[14] = '{16'h4000, 16'hBFC0, 16'h3F00};
        vecs[15] = '{16'h0100, 16'h80C0, 16'h0000};
        vecs[16] = '{16'h8100, 16'h00C0, 16'h8000};
        vecs[17] = '{16'h8000, 16'h0000, 16'h0000};

        // Reset state, before and after a few clock edges.
        #3;
        check("reset_sum", bus.sum, 16'h0000);
        check("reset_valid", {15'b0, bus.out_valid}, 16'h0000);
        repeat (3) @(negedge clk);
        check("reset_sum_clk", bus.sum, 16'h0000);
        check("reset_valid_clk", {15'b0, bus.out_valid}, 16'h0000);
        rst_n = 1'b1;

        // Stream every vector in both operand orders with one idle gap.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].y);
            drive(vecs[i].b, vecs[i].a, vecs[i].y);
            if (i == 4) idle();
        end
        idle();
        idle();
        repeat (2) @(negedge clk);
        check("drain_queue_empty", 16'(sb_q.size()), 16'h0000);

        // Asynchronous reset mid-stream discards the in-flight result.
        drive(16'h3FC0, 16'h4020, 16'h4080);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'h40B0;
        bus.b        = 16'h4124;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_sum", bus.sum, 16'h0000);
        check("async_reset_valid", {15'b0, bus.out_valid}, 16'h0000);
        @(negedge clk);
        check("reset_hold_sum", bus.sum, 16'h0000);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle();
        drive(16'hC000, 16'hC040, 16'hC0A0);
        idle();
        repeat (2) @(negedge clk);
        check("final_queue_empty", 16'(sb_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
